// File: rtl/ir_pkg.sv
// IR convolution sequencer shared types and default geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ir_pkg;

    localparam int MEMORY_DEPTH = 6000;
    localparam int NUM_BANKS    = 4;
    localparam int RAM_LATENCY  = 2;
    localparam int IR_LEN       = MEMORY_DEPTH * NUM_BANKS;
    localparam int TAP_IDX_W    = 13;
    localparam int LOAD_IDX_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SWEEP,
        ST_DRAIN
    } seq_state_t;

endpackage

// File: rtl/tap_valid_pipe.sv
// Delays the sweep issue strobe, last flag and read index to line up with buffer read data.
// Latency: DEPTH cycles, fixed.
// Backpressure: none; the stages shift every cycle.
module tap_valid_pipe #(
    parameter int DEPTH = ir_pkg::RAM_LATENCY,
    parameter int IDX_W = ir_pkg::TAP_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [IDX_W-1:0] in_index,
    output logic             out_valid,
    output logic             out_last,
    output logic [IDX_W-1:0] out_index
);

    logic [DEPTH-1:0] vld_sr;
    logic [DEPTH-1:0] last_sr;
    logic [IDX_W-1:0] idx_sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            last_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_sr[i] <= '0;
            end
        end else begin
            vld_sr[0]  <= in_valid;
            last_sr[0] <= in_last;
            idx_sr[0]  <= in_index;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
                idx_sr[i]  <= idx_sr[i-1];
            end
        end
    end

    assign out_valid = vld_sr[DEPTH-1];
    assign out_last  = last_sr[DEPTH-1];
    assign out_index = idx_sr[DEPTH-1];

endmodule

// File: rtl/ir_conv_sequencer.sv
// Loads the IR into the banked coefficient buffer and sweeps it once per audio sample tick.
// Latency: write one cycle after accept; tap_valid RAM_LATENCY cycles after each read address.
// Backpressure: ir_load_ready only in LOAD; ticks arriving while busy are dropped and flagged in overrun.
module ir_conv_sequencer #(
    parameter int MEMORY_DEPTH = ir_pkg::MEMORY_DEPTH,
    parameter int NUM_BANKS    = ir_pkg::NUM_BANKS,
    parameter int RAM_LATENCY  = ir_pkg::RAM_LATENCY
) (
    input  logic               audio_clk,
    input  logic               rst_in_n,
    input  logic               ir_load_start,
    input  logic signed [15:0] ir_load_data,
    input  logic               ir_load_valid,
    output logic               ir_load_ready,
    input  logic               sample_tick,
    input  logic               overrun_clr,
    output logic        [15:0] ir_sample_index,
    output logic signed [15:0] write_data,
    output logic               write_enable,
    output logic               ir_data_in_valid,
    output logic        [12:0] first_ir_index,
    output logic        [12:0] second_ir_index,
    output logic               tap_valid,
    output logic        [12:0] tap_index,
    output logic               tap_last,
    output logic               busy,
    output logic               ir_loaded,
    output logic               overrun
);

    import ir_pkg::*;

    localparam int LOAD_LEN = MEMORY_DEPTH * NUM_BANKS;
    localparam logic [LOAD_IDX_W-1:0] LOAD_LAST  = LOAD_IDX_W'(LOAD_LEN - 1);
    localparam logic [TAP_IDX_W-1:0]  K_LAST     = TAP_IDX_W'(MEMORY_DEPTH - 2);
    localparam logic [3:0]            DRAIN_LAST = 4'(RAM_LATENCY - 1);

    seq_state_t            state;
    seq_state_t            next_state;
    logic [LOAD_IDX_W-1:0] load_cnt;
    logic [TAP_IDX_W-1:0]  k_q;
    logic [TAP_IDX_W-1:0]  k2_q;
    logic [TAP_IDX_W-1:0]  k_nxt;
    logic [3:0]            drain_cnt;
    logic                  load_pending;
    logic                  load_go;
    logic                  accept;
    logic                  overrun_set;
    logic                  issue_vld;
    logic                  issue_last;

    assign ir_load_ready   = (state == ST_LOAD);
    assign accept          = ir_load_valid & ir_load_ready;
    // A load requested during a sweep is replayed from IDLE once the sweep has drained.
    assign load_go         = (state == ST_IDLE) & (ir_load_start | load_pending);
    assign overrun_set     = sample_tick & ((state != ST_IDLE) | load_go);
    assign busy            = (state != ST_IDLE);
    assign first_ir_index  = k_q;
    assign second_ir_index = k2_q;
    assign issue_vld       = (state == ST_SWEEP);
    assign issue_last      = (state == ST_SWEEP) & (k_q == K_LAST);

    always_comb begin
        next_state = state;
        k_nxt      = '0;
        case (state)
            ST_IDLE: begin
                if (load_go) begin
                    next_state = ST_LOAD;
                end else if (sample_tick && ir_loaded) begin
                    next_state = ST_SWEEP;
                end
            end
            ST_LOAD: begin
                if (accept && !ir_load_start && load_cnt == LOAD_LAST) begin
                    next_state = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (k_q == K_LAST) begin
                    next_state = ST_DRAIN;
                end else begin
                    k_nxt = k_q + 13'd2;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state            <= ST_IDLE;
            load_cnt         <= '0;
            k_q              <= '0;
            k2_q             <= '0;
            drain_cnt        <= '0;
            load_pending     <= 1'b0;
            ir_loaded        <= 1'b0;
            overrun          <= 1'b0;
            write_enable     <= 1'b0;
            ir_data_in_valid <= 1'b0;
            ir_sample_index  <= '0;
            write_data       <= '0;
        end else begin
            state            <= next_state;
            write_enable     <= accept;
            ir_data_in_valid <= accept;
            if (accept) begin
                ir_sample_index <= ir_load_start ? '0 : load_cnt;
                write_data      <= ir_load_data;
            end

            // A restart inside LOAD turns the beat accepted in that cycle into index 0.
            if (load_go) begin
                load_cnt <= '0;
            end else if (state == ST_LOAD) begin
                if (ir_load_start) begin
                    load_cnt <= {15'd0, accept};
                end else if (accept) begin
                    load_cnt <= load_cnt + 16'd1;
                end
            end

            if (load_go) begin
                ir_loaded <= 1'b0;
            end else if (state == ST_LOAD && next_state == ST_IDLE) begin
                ir_loaded <= 1'b1;
            end

            if ((state == ST_SWEEP || state == ST_DRAIN) && ir_load_start) begin
                load_pending <= 1'b1;
            end else if (state == ST_IDLE) begin
                load_pending <= 1'b0;
            end

            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 4'd1 : 4'd0;

            if (next_state == ST_SWEEP) begin
                k_q  <= k_nxt;
                k2_q <= k_nxt + 13'd1;
            end else begin
                k_q  <= '0;
                k2_q <= '0;
            end

            overrun <= overrun_set | (overrun & ~overrun_clr);
        end
    end

    tap_valid_pipe #(
        .DEPTH (RAM_LATENCY),
        .IDX_W (TAP_IDX_W)
    ) u_tap_pipe (
        .clk       (audio_clk),
        .rst_n     (rst_in_n),
        .in_valid  (issue_vld),
        .in_last   (issue_last),
        .in_index  (k_q),
        .out_valid (tap_valid),
        .out_last  (tap_last),
        .out_index (tap_index)
    );

endmodule

// File: tb/tb_ir_conv_sequencer.sv
// Scoreboard bench for ir_conv_sequencer at reduced geometry: randomized loads and sweeps
// against queued expectations, plus cycle-exact checks of sweep start, drain and reload timing.
module tb_ir_conv_sequencer;

    localparam int MD  = 100;
    localparam int NB  = 4;
    localparam int LAT = 2;
    localparam int LEN = MD * NB;
    localparam int NSW = MD / 2;

    typedef struct packed {
        logic [15:0] idx;
        logic [15:0] dat;
    } wr_t;

    typedef struct packed {
        logic [12:0] idx;
        logic        last;
    } tap_t;

    logic        audio_clk;
    logic        rst_in_n;
    logic        ir_load_start;
    logic [15:0] ir_load_data;
    logic        ir_load_valid;
    logic        ir_load_ready;
    logic        sample_tick;
    logic        overrun_clr;
    logic [15:0] ir_sample_index;
    logic [15:0] write_data;
    logic        write_enable;
    logic        ir_data_in_valid;
    logic [12:0] first_ir_index;
    logic [12:0] second_ir_index;
    logic        tap_valid;
    logic [12:0] tap_index;
    logic        tap_last;
    logic        busy;
    logic        ir_loaded;
    logic        overrun;

    int   vectors;
    int   fails;
    wr_t  write_q[$];
    tap_t tap_q[$];

    logic [LAT-1:0] h_vld;
    logic [12:0]    h_idx [LAT];

    ir_conv_sequencer #(
        .MEMORY_DEPTH (MD),
        .NUM_BANKS    (NB),
        .RAM_LATENCY  (LAT)
    ) dut (
        .audio_clk        (audio_clk),
        .rst_in_n         (rst_in_n),
        .ir_load_start    (ir_load_start),
        .ir_load_data     (ir_load_data),
        .ir_load_valid    (ir_load_valid),
        .ir_load_ready    (ir_load_ready),
        .sample_tick      (sample_tick),
        .overrun_clr      (overrun_clr),
        .ir_sample_index  (ir_sample_index),
        .write_data       (write_data),
        .write_enable     (write_enable),
        .ir_data_in_valid (ir_data_in_valid),
        .first_ir_index   (first_ir_index),
        .second_ir_index  (second_ir_index),
        .tap_valid        (tap_valid),
        .tap_index        (tap_index),
        .tap_last         (tap_last),
        .busy             (busy),
        .ir_loaded        (ir_loaded),
        .overrun          (overrun)
    );

    initial audio_clk = 1'b0;
    always #5 audio_clk = ~audio_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge audio_clk);
        #1;
    endtask

    // Monitor: pops the scoreboards and checks read-address to tap alignment.
    always @(negedge audio_clk) begin
        if (!rst_in_n) begin
            h_vld = '0;
            for (int i = 0; i < LAT; i++) h_idx[i] = '0;
        end else begin
            if (write_enable) begin
                if (write_q.size() == 0) begin
                    chk("wr_unexpected", {31'd0, write_enable}, 32'd0);
                end else begin
                    wr_t w;
                    w = write_q.pop_front();
                    chk("wr_index", ir_sample_index, w.idx);
                    chk("wr_data", write_data, w.dat);
                    chk("wr_sel", ir_data_in_valid, 1);
                end
            end else if (ir_data_in_valid) begin
                chk("wr_sel_stray", ir_data_in_valid, 0);
            end
            if (tap_valid) begin
                if (tap_q.size() == 0) begin
                    chk("tap_unexpected", {31'd0, tap_valid}, 32'd0);
                end else begin
                    tap_t t;
                    t = tap_q.pop_front();
                    chk("tap_index", tap_index, t.idx);
                    chk("tap_last", tap_last, t.last);
                end
            end
            if (tap_valid || h_vld[LAT-1]) begin
                chk("tap_align", tap_valid, h_vld[LAT-1]);
                chk("tap_align_idx", tap_index, h_idx[LAT-1]);
            end
            if (second_ir_index != 0) begin
                chk("pair_addr", second_ir_index, first_ir_index + 13'd1);
            end
            for (int i = LAT - 1; i > 0; i--) begin
                h_vld[i] = h_vld[i-1];
                h_idx[i] = h_idx[i-1];
            end
            h_vld[0] = (second_ir_index != 0);
            h_idx[0] = first_ir_index;
        end
    end

    // mode 0: valid every cycle, 1: alternating 1/0, 2: random gaps.
    task automatic load_ir(input bit pulse, input int mode, input bit with_tick);
        int idx;
        int guard;
        bit v;
        logic [15:0] d;
        wr_t w;
        if (pulse) begin
            ir_load_start = 1'b1;
            sample_tick   = with_tick;
            tick();
            ir_load_start = 1'b0;
            sample_tick   = 1'b0;
            if (with_tick) chk("ovr_load_tick", overrun, 1);
        end
        chk("ld_ready", ir_load_ready, 1);
        chk("ld_busy", busy, 1);
        chk("ld_loaded0", ir_loaded, 0);
        idx   = 0;
        guard = 0;
        while (idx < LEN && guard < 8 * LEN) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = 16'($urandom);
            ir_load_valid = v;
            ir_load_data  = d;
            if (v) begin
                w.idx = 16'(idx);
                w.dat = d;
                write_q.push_back(w);
                idx++;
            end
            guard++;
            tick();
        end
        ir_load_valid = 1'b0;
        chk("ld_done_ready", ir_load_ready, 0);
        chk("ld_done_loaded", ir_loaded, 1);
        chk("ld_done_busy", busy, 0);
        tick();
        chk("ld_writes_left", write_q.size(), 0);
    endtask

    // ev 0: none, 1: tick mid-sweep, 2: load request mid-sweep, 3: reset mid-sweep.
    task automatic run_sweep(input int ev, input int ev_cyc);
        int   c;
        tap_t t;
        for (int i = 0; i < NSW; i++) begin
            t.idx  = 13'(2 * i);
            t.last = (i == NSW - 1);
            tap_q.push_back(t);
        end
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        c = 1;
        chk("sw_busy", busy, 1);
        chk("sw_first0", first_ir_index, 0);
        chk("sw_second0", second_ir_index, 1);
        chk("sw_tv_c1", tap_valid, 0);
        chk("sw_no_wr", write_enable, 0);
        tick(); c++;
        chk("sw_first_c2", first_ir_index, 2);
        chk("sw_tv_c2", tap_valid, 0);
        tick(); c++;
        chk("sw_tv_c3", tap_valid, 1);
        chk("sw_tidx_c3", tap_index, 0);
        while (c < ev_cyc) begin
            tick(); c++;
        end
        case (ev)
            1: begin
                sample_tick = 1'b1;
                tick(); c++;
                sample_tick = 1'b0;
                chk("ovr_set", overrun, 1);
                tick(); tick(); c += 2;
                sample_tick = 1'b1;
                overrun_clr = 1'b1;
                tick(); c++;
                sample_tick = 1'b0;
                overrun_clr = 1'b0;
                chk("ovr_set_wins", overrun, 1);
            end
            2: begin
                ir_load_start = 1'b1;
                tick(); c++;
                ir_load_start = 1'b0;
                chk("pend_ready", ir_load_ready, 0);
                chk("pend_loaded", ir_loaded, 1);
            end
            3: begin
                rst_in_n = 1'b0;
                #1;
                chk("rst_tv", tap_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_first", first_ir_index, 0);
                chk("rst_second", second_ir_index, 0);
                chk("rst_loaded", ir_loaded, 0);
                chk("rst_ovr", overrun, 0);
                tap_q.delete();
                return;
            end
            default: ;
        endcase
        while (c < NSW + 2) begin
            tick(); c++;
        end
        chk("drain_busy", busy, 1);
        chk("drain_addr", first_ir_index, 0);
        chk("drain_last_tv", tap_valid, 1);
        chk("drain_last_flag", tap_last, 1);
        tick(); c++;
        chk("sw_done_busy", busy, 0);
        chk("sw_taps_left", tap_q.size(), 0);
        chk("sw_done_ready", ir_load_ready, 0);
        if (ev == 2) begin
            tick();
            chk("reload_ready", ir_load_ready, 1);
            chk("reload_loaded", ir_loaded, 0);
        end else begin
            chk("sw_loaded", ir_loaded, 1);
        end
    endtask

    initial begin
        vectors       = 0;
        fails         = 0;
        rst_in_n      = 1'b0;
        ir_load_start = 1'b0;
        ir_load_data  = '0;
        ir_load_valid = 1'b0;
        sample_tick   = 1'b0;
        overrun_clr   = 1'b0;
        tick(); tick();
        chk("rst_busy0", busy, 0);
        chk("rst_ready0", ir_load_ready, 0);
        chk("rst_we0", write_enable, 0);
        chk("rst_tv0", tap_valid, 0);
        chk("rst_ovr0", overrun, 0);
        chk("rst_loaded0", ir_loaded, 0);
        chk("rst_addr0", first_ir_index, 0);
        rst_in_n = 1'b1;
        tick();

        // Tick with no IR present is ignored.
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        chk("notload_busy", busy, 0);
        chk("notload_ovr", overrun, 0);
        tick();
        chk("notload_addr", second_ir_index, 0);

        load_ir(1'b1, 0, 1'b0);
        run_sweep(1, 10);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", overrun, 0);

        load_ir(1'b1, 1, 1'b0);
        run_sweep(0, 0);

        run_sweep(2, 20);
        load_ir(1'b0, 2, 1'b0);

        run_sweep(3, 25);
        tick(); tick();
        rst_in_n = 1'b1;
        tick();
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        chk("postrst_busy", busy, 0);
        chk("postrst_ovr", overrun, 0);
        tick();
        chk("postrst_busy2", busy, 0);
        chk("postrst_addr", second_ir_index, 0);

        // Load and tick together: load wins, tick counts as dropped.
        load_ir(1'b1, 2, 1'b1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr2", overrun, 0);
        run_sweep(0, 0);
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
